// File: rtl/showcase0_pkg.sv
// Shared record layout for Showcase0 result capture.
// Packing lives here so a future unpacker agrees on field placement.
package showcase0_pkg;

  localparam int RECORD_WIDTH = 46;
  localparam int REC_C_LSB    = 0;
  localparam int REC_CMP_LSB  = 32;
  localparam int REC_SC_LSB   = 38;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  function automatic logic [RECORD_WIDTH-1:0] pack_record(
    input logic [31:0] c,
    input logic [5:0]  cmp,
    input logic [7:0]  sc
  );
    logic [RECORD_WIDTH-1:0] r;
    r = '0;
    r[REC_C_LSB   +: 32] = c;
    r[REC_CMP_LSB +: 6]  = cmp;
    r[REC_SC_LSB  +: 8]  = sc;
    return r;
  endfunction

endpackage

// File: rtl/showcase0_fifo_mem.sv
// Record storage for the result FIFO.
// Synchronous write, asynchronous read, no reset.
module showcase0_fifo_mem
  import showcase0_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(DEPTH)-1:0]    waddr,
  input  logic [RECORD_WIDTH-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0]    raddr,
  output logic [RECORD_WIDTH-1:0]     rdata
);

  logic [RECORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/showcase0_result_fifo.sv
// Captures Showcase0 results into a small FIFO with drop counting.
// Samples arriving while full (and not being drained) are discarded.
module showcase0_result_fifo
  import showcase0_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dataIn_vld,
  input  logic [31:0]               c,
  input  logic [5:0]                cmp,
  input  logic [7:0]                sc_signal,
  output logic [RECORD_WIDTH-1:0]   dataOut_data,
  output logic                      dataOut_vld,
  input  logic                      dataOut_rd,
  output logic [$clog2(DEPTH):0]    size,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] FULL_SIZE = SW'(DEPTH);

  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [RECORD_WIDTH-1:0] rdata;
  logic                    rd_en;
  logic                    wr_en;
  logic                    drop;
  occ_e                    occ;

  always_comb begin
    occ = OCC_PARTIAL;
    unique case (1'b1)
      (size == '0):        occ = OCC_EMPTY;
      (size == FULL_SIZE): occ = OCC_FULL;
      default:             occ = OCC_PARTIAL;
    endcase
  end

  assign dataOut_vld = (occ != OCC_EMPTY);
  assign rd_en = dataOut_vld && dataOut_rd;
  // Draining a full FIFO frees the slot in the same cycle.
  assign wr_en = dataIn_vld && ((occ != OCC_FULL) || rd_en);
  assign drop  = dataIn_vld && (occ == OCC_FULL) && !rd_en;

  showcase0_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && !rst),
    .waddr (wr_ptr),
    .wdata (pack_record(c, cmp, sc_signal)),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      size     <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en) size <= size + SW'(1);
      if (rd_en && !wr_en) size <= size - SW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign dataOut_data = dataOut_vld ? rdata : '0;

endmodule

// File: tb/tb_showcase0_result_fifo.sv
// Bench for showcase0_result_fifo: table vectors, corner sequences,
// and random traffic against a queue-based reference model.
module tb_showcase0_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [31:0] c   = '0;
  logic [5:0]  cmp = '0;
  logic [7:0]  sc  = '0;
  logic        rd  = 1'b0;

  logic [45:0] data, data_s;
  logic        dvld, dvld_s;
  logic [2:0]  size, size_s;
  logic [15:0] drop;
  logic [1:0]  drop_s;
  logic        ovf, ovf_s;

  always #5 clk = ~clk;

  showcase0_result_fifo #(
    .DEPTH(DEPTH), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .dataIn_vld(vld), .c(c), .cmp(cmp),
    .sc_signal(sc), .dataOut_data(data), .dataOut_vld(dvld),
    .dataOut_rd(rd), .size(size), .drop_cnt(drop), .overflow(ovf)
  );

  showcase0_result_fifo #(
    .DEPTH(DEPTH), .DROP_CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .dataIn_vld(vld), .c(c), .cmp(cmp),
    .sc_signal(sc), .dataOut_data(data_s), .dataOut_vld(dvld_s),
    .dataOut_rd(rd), .size(size_s), .drop_cnt(drop_s), .overflow(ovf_s)
  );

  int checks = 0;
  int failures = 0;

  logic [45:0] q[$];
  int          drops = 0;
  bit          ovf_m = 1'b0;

  typedef struct {
    bit          v;
    logic [31:0] c;
    logic [5:0]  cmp;
    logic [7:0]  sc;
    bit          rd;
    int          e_size;
    bit          e_vld;
    logic [45:0] e_data;
    int          e_drop;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit v, logic [31:0] cc, logic [5:0] cm,
                              logic [7:0] s, bit r, int es, bit ev,
                              logic [45:0] ed, int edr, bit eo);
    vec_t t;
    t.v = v; t.c = cc; t.cmp = cm; t.sc = s; t.rd = r;
    t.e_size = es; t.e_vld = ev; t.e_data = ed;
    t.e_drop = edr; t.e_ovf = eo;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit v, logic [31:0] cc, logic [5:0] cm,
                       logic [7:0] s, bit r);
    bit rd_ok;
    bit acc;
    vld = v; c = cc; cmp = cm; sc = s; rd = r;
    rd_ok = r && (q.size() != 0);
    acc = v && ((q.size() < DEPTH) || rd_ok);
    if (v && !acc) begin
      drops++;
      ovf_m = 1'b1;
    end
    if (rd_ok) void'(q.pop_front());
    if (acc) q.push_back({s, cm, cc});
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [45:0] ed;
    ed = (q.size() != 0) ? q[0] : '0;
    chk("size", size, q.size());
    chk("vld", dvld, q.size() != 0);
    chk("data", data, ed);
    chk("drop", drop, (drops > 65535) ? 65535 : drops);
    chk("ovf", ovf, ovf_m);
    chk("sat_size", size_s, q.size());
    chk("sat_vld", dvld_s, q.size() != 0);
    chk("sat_data", data_s, ed);
    chk("sat_drop", drop_s, (drops > 3) ? 3 : drops);
    chk("sat_ovf", ovf_s, ovf_m);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b1; rd = 1'b1; c = $urandom;
    @(posedge clk);
    #1;
    rst = 1'b0; vld = 1'b0; rd = 1'b0;
    q.delete();
    drops = 0;
    ovf_m = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 6'h01, 8'h00, 1, 1, 1, 46'h0001_0000_0001, 0, 0);
    tbl[1]  = mk(1, 2, 6'h01, 8'h01, 1, 1, 1, 46'h0041_0000_0002, 0, 0);
    tbl[2]  = mk(1, 3, 6'h01, 8'h03, 1, 1, 1, 46'h00C1_0000_0003, 0, 0);
    tbl[3]  = mk(0, 0, 6'h00, 8'h00, 1, 0, 0, 46'h0, 0, 0);
    tbl[4]  = mk(1, 32'h10, 6'h02, 8'h10, 0, 1, 1, 46'h0402_0000_0010, 0, 0);
    tbl[5]  = mk(1, 32'h11, 6'h02, 8'h10, 0, 2, 1, 46'h0402_0000_0010, 0, 0);
    tbl[6]  = mk(1, 32'h12, 6'h02, 8'h10, 0, 3, 1, 46'h0402_0000_0010, 0, 0);
    tbl[7]  = mk(1, 32'h13, 6'h02, 8'h10, 0, 4, 1, 46'h0402_0000_0010, 0, 0);
    tbl[8]  = mk(1, 32'h14, 6'h02, 8'h10, 0, 4, 1, 46'h0402_0000_0010, 1, 1);
    tbl[9]  = mk(1, 32'h15, 6'h02, 8'h10, 0, 4, 1, 46'h0402_0000_0010, 2, 1);
    tbl[10] = mk(0, 0, 6'h00, 8'h00, 1, 3, 1, 46'h0402_0000_0011, 2, 1);
    tbl[11] = mk(0, 0, 6'h00, 8'h00, 1, 2, 1, 46'h0402_0000_0012, 2, 1);
    tbl[12] = mk(0, 0, 6'h00, 8'h00, 1, 1, 1, 46'h0402_0000_0013, 2, 1);
    tbl[13] = mk(0, 0, 6'h00, 8'h00, 1, 0, 0, 46'h0, 2, 1);

    do_reset();
    chk("rst_size", size, 0);
    chk("rst_vld", dvld, 0);
    chk("rst_data", data, 0);
    chk("rst_drop", drop, 0);
    chk("rst_ovf", ovf, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].cmp, tbl[i].sc, tbl[i].rd);
      chk($sformatf("tbl%0d_size", i), size, tbl[i].e_size);
      chk($sformatf("tbl%0d_vld", i), dvld, tbl[i].e_vld);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
      chk($sformatf("tbl%0d_drop", i), drop, tbl[i].e_drop);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
    end

    // Full FIFO with simultaneous read and write every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom, 6'($urandom), 8'($urandom), 0);
      check_model();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 6'($urandom), 8'($urandom), 1);
      check_model();
      chk("full_rw_size", size, 4);
      chk("full_rw_drop", drop, 0);
    end

    // Pointer wrap, one record in flight.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, $urandom, 6'($urandom), 8'($urandom), 0);
      check_model();
      drive(0, $urandom, 6'($urandom), 8'($urandom), 1);
      check_model();
      chk("wrap_empty_data", data, 0);
    end

    // Reset mid-stream with overflow set.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 32'h100 + i, 6'h3F, 8'hAA, 0);
    drive(0, 0, 0, 0, 1);
    chk("mid_size", size, 3);
    chk("mid_ovf", ovf, 1);
    do_reset();
    chk("mid_rst_size", size, 0);
    chk("mid_rst_vld", dvld, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_ovf", ovf, 0);
    drive(1, 32'hDEAD_BEEF, 6'h15, 8'h5A, 0);
    check_model();
    chk("post_rst_data", data, 46'h1695_DEAD_BEEF);

    // Saturation of the narrow drop counter.
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, i, 6'h00, 8'h00, 0);
    chk("sat_cnt", drop_s, 3);
    chk("wide_cnt", drop, 5);
    check_model();

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive($urandom_range(0, 9) < 7, $urandom, 6'($urandom),
                 8'($urandom), $urandom_range(0, 1) == 1);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
